board_select_ctl: RTL and testbench

- Produces the per-cell square flags that the square draw stages consume. The draw stages use those flags to overlay cell colours on the VGA stream.
- Converts mouse position plus left-button clicks into claimed cells on the 3x3 board, alternating between player X and player O.
- Evaluates win and draw after every claim and freezes the board once the game ends.
- Sits between the mouse interface (position/button, in the pclk domain) and the chain of square draw stages.

---
 rtl/board_pkg.sv | 47 ++++
 rtl/board_cell_decode.sv | 44 ++++
 rtl/board_select_ctl.sv | 165 ++++++++++++++++
 tb/tb_board_select_ctl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared types and constants for the 3x3 board select controller.
package board_pkg;

    localparam int unsigned CELL_CNT   = 9;
    localparam int unsigned CELL_IDX_W = 4;
    localparam int unsigned LINE_CNT   = 8;
    localparam int unsigned POS_W      = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PLAY  = 2'b01,
        CHECK = 2'b10,
        DONE  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_X    = 2'b01,
        WIN_O    = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

    // Cell k = row*3 + col; bit0 is top-left.
    localparam logic [LINE_CNT-1:0][CELL_CNT-1:0] LINE_MASK = {
        9'b001_010_100,   // anti-diagonal 2,4,6
        9'b100_010_001,   // diagonal 0,4,8
        9'b100_100_100,   // column 2
        9'b010_010_010,   // column 1
        9'b001_001_001,   // column 0
        9'b111_000_000,   // row 2
        9'b000_111_000,   // row 1
        9'b000_000_111    // row 0
    };

    // True when any of the 8 lines is fully owned in the given board.
    function automatic logic has_line(input logic [CELL_CNT-1:0] board);
        logic r_hit;
        r_hit = 1'b0;
        for (int i = 0; i < int'(LINE_CNT); i++) begin
            if ((board & LINE_MASK[i]) == LINE_MASK[i]) begin
                r_hit = 1'b1;
            end
        end
        return r_hit;
    endfunction

endpackage

// File: rtl/board_cell_decode.sv
// Combinational map from cursor position to board cell index.
module board_cell_decode
    import board_pkg::*;
#(
    parameter int unsigned X1   = 339,
    parameter int unsigned X2   = 682,
    parameter int unsigned XMAX = 1024,
    parameter int unsigned Y1   = 252,
    parameter int unsigned Y2   = 508,
    parameter int unsigned YMAX = 768
) (
    input  logic [POS_W-1:0]      i_xpos,
    input  logic [POS_W-1:0]      i_ypos,
    output logic [CELL_IDX_W-1:0] o_cell_idx_c,
    output logic                  o_cell_valid_c
);

    logic [1:0] w_col;
    logic [1:0] w_row;
    logic       w_on_board;

    // Column/row bands and on-board qualification.
    always_comb begin
        w_col = 2'd2;
        w_row = 2'd2;
        if (i_xpos < POS_W'(X1)) begin
            w_col = 2'd0;
        end else if (i_xpos < POS_W'(X2)) begin
            w_col = 2'd1;
        end
        if (i_ypos < POS_W'(Y1)) begin
            w_row = 2'd0;
        end else if (i_ypos < POS_W'(Y2)) begin
            w_row = 2'd1;
        end
        w_on_board     = (i_xpos < POS_W'(XMAX)) && (i_ypos < POS_W'(YMAX));
        o_cell_valid_c = w_on_board;
        o_cell_idx_c   = '0;
        if (w_on_board) begin
            o_cell_idx_c = CELL_IDX_W'(w_row) * CELL_IDX_W'(3) + CELL_IDX_W'(w_col);
        end
    end

endmodule

// File: rtl/board_select_ctl.sv
// Turns mouse clicks into X/O claims on a 3x3 board and tracks win/draw.
module board_select_ctl
    import board_pkg::*;
#(
    parameter int unsigned X1   = 339,
    parameter int unsigned X2   = 682,
    parameter int unsigned XMAX = 1024,
    parameter int unsigned Y1   = 252,
    parameter int unsigned Y2   = 508,
    parameter int unsigned YMAX = 768
) (
    input  logic                pclk,
    input  logic                rst,
    input  logic                start_en,
    input  logic [POS_W-1:0]    mouse_xpos,
    input  logic [POS_W-1:0]    mouse_ypos,
    input  logic                mouse_left,
    output logic [CELL_CNT-1:0] square_x,
    output logic [CELL_CNT-1:0] square_o,
    output logic                turn,
    output logic [1:0]          winner,
    output logic                game_over
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_prev;
    logic                  w_click;
    logic [CELL_IDX_W-1:0] w_cell_idx;
    logic                  w_cell_valid;
    logic [CELL_CNT-1:0]   w_cell_bit;
    logic                  w_occupied;
    logic                  w_x_line;
    logic                  w_o_line;
    logic                  w_full;
    logic [CELL_CNT-1:0]   w_sq_x_nxt;
    logic [CELL_CNT-1:0]   w_sq_o_nxt;
    logic                  w_turn_nxt;
    logic [1:0]            w_winner_nxt;
    logic                  w_game_over_nxt;

    // Button synchronizer plus edge-detect register.
    always_ff @(posedge pclk) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= mouse_left;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_click = r_sync2 & ~r_prev;

    board_cell_decode #(
        .X1   (X1),
        .X2   (X2),
        .XMAX (XMAX),
        .Y1   (Y1),
        .Y2   (Y2),
        .YMAX (YMAX)
    ) u_decode (
        .i_xpos         (mouse_xpos),
        .i_ypos         (mouse_ypos),
        .o_cell_idx_c   (w_cell_idx),
        .o_cell_valid_c (w_cell_valid)
    );

    assign w_cell_bit = CELL_CNT'(1) << w_cell_idx;
    assign w_occupied = |((square_x | square_o) & w_cell_bit);
    assign w_x_line   = has_line(square_x);
    assign w_o_line   = has_line(square_o);
    assign w_full     = &(square_x | square_o);

    // State and registered outputs.
    always_ff @(posedge pclk) begin
        if (!rst) begin
            r_state   <= IDLE;
            square_x  <= '0;
            square_o  <= '0;
            turn      <= 1'b0;
            winner    <= WIN_NONE;
            game_over <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            square_x  <= w_sq_x_nxt;
            square_o  <= w_sq_o_nxt;
            turn      <= w_turn_nxt;
            winner    <= w_winner_nxt;
            game_over <= w_game_over_nxt;
        end
    end

    // Next state and next output values.
    always_comb begin
        w_state_nxt     = r_state;
        w_sq_x_nxt      = square_x;
        w_sq_o_nxt      = square_o;
        w_turn_nxt      = turn;
        w_winner_nxt    = winner;
        w_game_over_nxt = game_over;

        case (r_state)
            IDLE: begin
                if (start_en) begin
                    w_state_nxt = PLAY;
                end
            end
            PLAY: begin
                if (!start_en) begin
                    w_state_nxt = IDLE;
                end else if (w_click && w_cell_valid && !w_occupied) begin
                    if (!turn) begin
                        w_sq_x_nxt = square_x | w_cell_bit;
                    end else begin
                        w_sq_o_nxt = square_o | w_cell_bit;
                    end
                    w_turn_nxt  = ~turn;
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (!start_en) begin
                    w_state_nxt = IDLE;
                end else if (w_x_line) begin
                    w_winner_nxt    = WIN_X;
                    w_game_over_nxt = 1'b1;
                    w_state_nxt     = DONE;
                end else if (w_o_line) begin
                    w_winner_nxt    = WIN_O;
                    w_game_over_nxt = 1'b1;
                    w_state_nxt     = DONE;
                end else if (w_full) begin
                    w_winner_nxt    = WIN_DRAW;
                    w_game_over_nxt = 1'b1;
                    w_state_nxt     = DONE;
                end else begin
                    w_state_nxt = PLAY;
                end
            end
            DONE: begin
                if (!start_en) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Entering or staying in IDLE always presents a cleared board.
        if (w_state_nxt == IDLE) begin
            w_sq_x_nxt      = '0;
            w_sq_o_nxt      = '0;
            w_turn_nxt      = 1'b0;
            w_winner_nxt    = WIN_NONE;
            w_game_over_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_board_select_ctl.sv
// Randomized and directed bench for board_select_ctl with a cell-array model.
module tb_board_select_ctl;

    logic        pclk = 1'b0;
    logic        rst;
    logic        start_en;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic        mouse_left;
    logic [8:0]  square_x;
    logic [8:0]  square_o;
    logic        turn;
    logic [1:0]  winner;
    logic        game_over;

    always #5 pclk = ~pclk;

    board_select_ctl dut (
        .pclk       (pclk),
        .rst        (rst),
        .start_en   (start_en),
        .mouse_xpos (mouse_xpos),
        .mouse_ypos (mouse_ypos),
        .mouse_left (mouse_left),
        .square_x   (square_x),
        .square_o   (square_o),
        .turn       (turn),
        .winner     (winner),
        .game_over  (game_over)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Model: owner per cell (0 empty, 1 X, 2 O), side to move, result code.
    int m_cell [9];
    int m_turn;
    int m_win;

    function automatic int cell_of(int x, int y);
        int c;
        int r;
        if (x >= 1024 || y >= 768) return -1;
        c = (x < 339) ? 0 : (x < 682) ? 1 : 2;
        r = (y < 252) ? 0 : (y < 508) ? 1 : 2;
        return r * 3 + c;
    endfunction

    function automatic int result_of_board();
        int xl = 0;
        int ol = 0;
        int full = 1;
        int a, b, c;
        for (int l = 0; l < 8; l++) begin
            if (l < 3) begin a = 3 * l; b = a + 1; c = a + 2; end
            else if (l < 6) begin a = l - 3; b = a + 3; c = a + 6; end
            else if (l == 6) begin a = 0; b = 4; c = 8; end
            else begin a = 2; b = 4; c = 6; end
            if (m_cell[a] != 0 && m_cell[a] == m_cell[b] && m_cell[a] == m_cell[c]) begin
                if (m_cell[a] == 1) xl = 1; else ol = 1;
            end
        end
        for (int k = 0; k < 9; k++) if (m_cell[k] == 0) full = 0;
        if (xl != 0) return 1;
        if (ol != 0) return 2;
        if (full != 0) return 3;
        return 0;
    endfunction

    function automatic logic [8:0] board_of(int who);
        logic [8:0] v = '0;
        for (int k = 0; k < 9; k++) if (m_cell[k] == who) v[k] = 1'b1;
        return v;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 9; k++) m_cell[k] = 0;
        m_turn = 0;
        m_win  = 0;
    endfunction

    function automatic int cx(int k); return (k % 3) * 341 + 150; endfunction
    function automatic int cy(int k); return (k / 3) * 256 + 120; endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_state(input string tag, input int win_exp);
        chk({tag, ".square_x"}, 32'(square_x), 32'(board_of(1)));
        chk({tag, ".square_o"}, 32'(square_o), 32'(board_of(2)));
        chk({tag, ".turn"}, 32'(turn), 32'(m_turn));
        chk({tag, ".winner"}, 32'(winner), 32'(win_exp));
        chk({tag, ".game_over"}, 32'(game_over), 32'(win_exp != 0));
    endtask

    // One press/release at (x,y); checks the click cycle, the claim edge and the evaluation edge.
    task automatic click(input int x, input int y);
        int k;
        int new_win;
        @(negedge pclk);
        mouse_xpos = 12'(x);
        mouse_ypos = 12'(y);
        mouse_left = 1'b1;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        check_state("pre", m_win);
        k = cell_of(x, y);
        new_win = m_win;
        if (m_win == 0 && k >= 0 && m_cell[k] == 0) begin
            m_cell[k] = (m_turn != 0) ? 2 : 1;
            m_turn    = 1 - m_turn;
            new_win   = result_of_board();
        end
        @(negedge pclk);
        check_state("claim", m_win);
        mouse_left = 1'b0;
        m_win = new_win;
        @(negedge pclk);
        check_state("eval", m_win);
        repeat (3) @(negedge pclk);
    endtask

    task automatic drop_start();
        @(negedge pclk);
        start_en = 1'b0;
        model_clear();
        @(negedge pclk);
        check_state("drop", 0);
        start_en = 1'b1;
        @(negedge pclk);
    endtask

    initial begin
        int r, k, c, row, x, y, lo, hi;
        rst        = 1'b0;
        start_en   = 1'b1;
        mouse_xpos = '0;
        mouse_ypos = '0;
        mouse_left = 1'b0;
        model_clear();
        repeat (3) @(negedge pclk);
        check_state("reset", 0);
        rst = 1'b1;
        @(negedge pclk);

        // First claim and latency.
        click(100, 100);
        chk("first.sx", 32'(square_x), 32'h001);
        chk("first.turn", 32'(turn), 32'd1);
        // Second click on an occupied cell.
        click(100, 100);
        chk("dup.so", 32'(square_o), 32'h000);
        chk("dup.turn", 32'(turn), 32'd1);
        // Off-board clicks.
        click(1100, 100);
        click(100, 800);
        chk("off.turn", 32'(turn), 32'd1);
        // X wins down column 0.
        click(400, 100);
        click(100, 300);
        click(400, 300);
        click(100, 600);
        chk("xwin.sx", 32'(square_x), 32'h049);
        chk("xwin.winner", 32'(winner), 32'd1);
        chk("xwin.go", 32'(game_over), 32'd1);
        click(700, 700);
        chk("frozen.sx", 32'(square_x), 32'h049);
        chk("frozen.so", 32'(square_o), 32'h012);

        // Draw fill: X 0,1,5,6,8 and O 2,3,4,7.
        drop_start();
        click(cx(0), cy(0)); click(cx(2), cy(2)); click(cx(1), cy(1));
        click(cx(3), cy(3)); click(cx(5), cy(5)); click(cx(4), cy(4));
        click(cx(6), cy(6)); click(cx(7), cy(7)); click(cx(8), cy(8));
        chk("draw.winner", 32'(winner), 32'd3);
        chk("draw.sx", 32'(square_x), 32'h163);
        chk("draw.so", 32'(square_o), 32'h09C);

        // Drop start_en with three cells claimed.
        drop_start();
        click(cx(4), cy(4)); click(cx(0), cy(0)); click(cx(8), cy(8));
        drop_start();
        chk("drop.sx", 32'(square_x), 32'h000);
        chk("drop.turn", 32'(turn), 32'd0);

        // Button held for 100 cycles yields one claim.
        @(negedge pclk);
        mouse_xpos = 12'(cx(2));
        mouse_ypos = 12'(cy(2));
        mouse_left = 1'b1;
        m_cell[2] = 1;
        m_turn = 1;
        repeat (100) @(negedge pclk);
        check_state("hold", 0);
        mouse_xpos = 12'(cx(6));
        mouse_ypos = 12'(cy(6));
        mouse_left = 1'b0;
        repeat (4) @(negedge pclk);
        check_state("hold.rel", 0);
        chk("hold.sx", 32'(square_x), 32'h004);

        // Randomized games, alternating restart by reset and by start_en.
        for (int g = 0; g < 8; g++) begin
            if (g % 2 == 0) begin
                @(negedge pclk);
                rst = 1'b0;
                model_clear();
                @(negedge pclk);
                check_state("rreset", 0);
                rst = 1'b1;
                @(negedge pclk);
            end else begin
                drop_start();
            end
            for (int i = 0; i < 14; i++) begin
                r = int'($urandom_range(0, 9));
                if (r < 2) begin
                    x = int'($urandom_range(0, 1200));
                    y = int'($urandom_range(0, 900));
                end else begin
                    k   = int'($urandom_range(0, 8));
                    c   = k % 3;
                    row = k / 3;
                    lo  = (c == 0) ? 0 : (c == 1) ? 339 : 682;
                    hi  = (c == 0) ? 338 : (c == 1) ? 681 : 1023;
                    x   = (r == 2) ? lo : (r == 3) ? hi : int'($urandom_range(hi, lo));
                    lo  = (row == 0) ? 0 : (row == 1) ? 252 : 508;
                    hi  = (row == 0) ? 251 : (row == 1) ? 507 : 767;
                    y   = (r == 4) ? lo : (r == 5) ? hi : int'($urandom_range(hi, lo));
                end
                click(x, y);
                chk("disjoint", 32'(square_x & square_o), 32'd0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
